// File: rtl/dup_pipelined_csel_adder.sv
// -----------------------------------------------------------------------------
// dup_pipelined_csel_adder
//
// Pipelined, duplicated carry-select adder with parity prediction. The WIDTH
// bit add is split into STAGES segments of SEG = WIDTH/STAGES bits, one
// segment per pipeline stage. Each segment holds two independent carry-select
// chains (BLOCK-bit blocks). The two chains are compared at the end, and the
// sum parity is checked against a prediction built from chain-2 carries.
//
// Optional build macro: FAULT_INJECT_EN adds port inj_mask, which is XORed onto
// the chain-2 sum just before the duplication compare (s is unaffected).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = !out_valid | out_ready)
//   a, b, pa, pb, c_in    operands, their even parities, carry in
//   out_valid / out_ready result handshake
//   s, c_out              chain-1 sum and carry out
//   err_in_par            operand parity mismatch for this result
//   err_dup               chain 1 / chain 2 disagreement for this result
//   err_par               predicted vs actual sum parity mismatch
//   err_sticky, err_count error record (count saturates), cleared by clr_err
//   inj_mask              (FAULT_INJECT_EN only) chain-2 sum corruption mask
// -----------------------------------------------------------------------------
module dup_pipelined_csel_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int BLOCK  = 4,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               pa,
    input  logic               pb,
    input  logic               c_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   s,
    output logic               c_out,
    output logic               err_in_par,
    output logic               err_dup,
    output logic               err_par,
    output logic               err_sticky,
    output logic [CNT_W-1:0]   err_count,
    input  logic               clr_err
`ifdef FAULT_INJECT_EN
    ,
    input  logic [WIDTH-1:0]   inj_mask
`endif
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NBLK = SEG / BLOCK;

    // One segment of carry-select addition: every block computes its sum for
    // both carry-in assumptions, the rippling block carry picks one.
    function automatic logic [SEG:0] csel_add(input logic [SEG-1:0] x,
                                              input logic [SEG-1:0] y,
                                              input logic           ci);
        logic [SEG:0]   res;
        logic           cy;
        logic [BLOCK:0] t0;
        logic [BLOCK:0] t1;
        res = '0;
        cy  = ci;
        for (int j = 0; j < NBLK; j++) begin
            t0 = {1'b0, x[j*BLOCK +: BLOCK]} + {1'b0, y[j*BLOCK +: BLOCK]};
            t1 = {1'b0, x[j*BLOCK +: BLOCK]} + {1'b0, y[j*BLOCK +: BLOCK]}
                 + {{BLOCK{1'b0}}, 1'b1};
            res[j*BLOCK +: BLOCK] = cy ? t1[BLOCK-1:0] : t0[BLOCK-1:0];
            cy = cy ? t1[BLOCK] : t0[BLOCK];
        end
        res[SEG] = cy;
        return res;
    endfunction

    // Even-parity check of an operand against its supplied parity bit.
    function automatic logic par_err(input logic [WIDTH-1:0] v, input logic p);
        return p != (^v);
    endfunction

    logic r_out_valid;
    logic w_advance;

    assign w_advance = !r_out_valid | out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DN = (k + 1) * SEG;   // sum bits produced up to here

        logic             w_vld;
        logic             w_c1;
        logic             w_c2;
        logic             w_pp;
        logic             w_ein;
        logic [SEG-1:0]   w_aseg;
        logic [SEG-1:0]   w_bseg;
        logic [SEG:0]     w_r1;
        logic [SEG:0]     w_r2;
        logic [SEG-1:0]   w_cv;
        logic [DN-1:0]    w_s1;
        logic [DN-1:0]    w_s2;

        assign w_r1 = csel_add(w_aseg, w_bseg, w_c1);
        assign w_r2 = csel_add(w_aseg, w_bseg, w_c2);
        // Carry into each bit of the segment, recovered from chain 2 as a^b^sum.
        assign w_cv = w_aseg ^ w_bseg ^ w_r2[SEG-1:0];

        if (k == 0) begin : g_src
            assign w_vld  = in_valid;
            assign w_c1   = c_in;
            assign w_c2   = c_in;
            assign w_ein  = par_err(a, pa) | par_err(b, pb);
            assign w_aseg = a[SEG-1:0];
            assign w_bseg = b[SEG-1:0];
            assign w_pp   = pa ^ pb ^ (^w_cv);
            assign w_s1   = w_r1[SEG-1:0];
            assign w_s2   = w_r2[SEG-1:0];
        end else begin : g_src
            assign w_vld  = g_stage[k-1].g_reg.r_vld;
            assign w_c1   = g_stage[k-1].g_reg.r_c1;
            assign w_c2   = g_stage[k-1].g_reg.r_c2;
            assign w_ein  = g_stage[k-1].g_reg.r_ein;
            // The forwarded operand register holds only unconsumed bits, so
            // this stage's segment sits at its bottom.
            assign w_aseg = g_stage[k-1].g_reg.r_a[SEG-1:0];
            assign w_bseg = g_stage[k-1].g_reg.r_b[SEG-1:0];
            assign w_pp   = g_stage[k-1].g_reg.r_pp ^ (^w_cv);
            assign w_s1   = {w_r1[SEG-1:0], g_stage[k-1].g_reg.r_s1};
            assign w_s2   = {w_r2[SEG-1:0], g_stage[k-1].g_reg.r_s2};
        end

        // The last segment feeds the output registers directly.
        if (k < STAGES - 1) begin : g_reg
            localparam int RM = WIDTH - DN;  // operand bits still to be added

            logic           r_vld;
            logic           r_c1;
            logic           r_c2;
            logic           r_pp;
            logic           r_ein;
            logic [RM-1:0]  r_a;
            logic [RM-1:0]  r_b;
            logic [DN-1:0]  r_s1;
            logic [DN-1:0]  r_s2;
            logic [RM-1:0]  w_a_rm;
            logic [RM-1:0]  w_b_rm;

            if (k == 0) begin : g_rm
                assign w_a_rm = a[WIDTH-1:DN];
                assign w_b_rm = b[WIDTH-1:DN];
            end else begin : g_rm
                assign w_a_rm = g_stage[k-1].g_reg.r_a[RM+SEG-1:SEG];
                assign w_b_rm = g_stage[k-1].g_reg.r_b[RM+SEG-1:SEG];
            end

            // Stage register: shifts on advance, bubbles travel like data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_c1  <= 1'b0;
                    r_c2  <= 1'b0;
                    r_pp  <= 1'b0;
                    r_ein <= 1'b0;
                    r_a   <= '0;
                    r_b   <= '0;
                    r_s1  <= '0;
                    r_s2  <= '0;
                end else if (w_advance) begin
                    r_vld <= w_vld;
                    r_c1  <= w_r1[SEG];
                    r_c2  <= w_r2[SEG];
                    r_pp  <= w_pp;
                    r_ein <= w_ein;
                    r_a   <= w_a_rm;
                    r_b   <= w_b_rm;
                    r_s1  <= w_s1;
                    r_s2  <= w_s2;
                end
            end
        end
    end

    logic [WIDTH-1:0] w_s1_fin;
    logic [WIDTH-1:0] w_s2_cmp;
    logic             w_vld_fin;
    logic             w_c1_fin;
    logic             w_c2_fin;
    logic             w_dup_fin;
    logic             w_par_fin;
    logic             w_ein_fin;

    assign w_s1_fin  = g_stage[STAGES-1].w_s1;
    assign w_vld_fin = g_stage[STAGES-1].w_vld;
    assign w_c1_fin  = g_stage[STAGES-1].w_r1[SEG];
    assign w_c2_fin  = g_stage[STAGES-1].w_r2[SEG];
    assign w_ein_fin = g_stage[STAGES-1].w_ein;
`ifdef FAULT_INJECT_EN
    assign w_s2_cmp  = g_stage[STAGES-1].w_s2 ^ inj_mask;
`else
    assign w_s2_cmp  = g_stage[STAGES-1].w_s2;
`endif
    assign w_dup_fin = (w_s1_fin != w_s2_cmp) | (w_c1_fin != w_c2_fin);
    // Parity prediction comes from the clean chain-2 carries, so injected
    // chain-2 corruption only shows up in the duplication check.
    assign w_par_fin = g_stage[STAGES-1].w_pp != (^w_s1_fin);

    logic [WIDTH-1:0] r_s;
    logic             r_c_out;
    logic             r_err_in_par;
    logic             r_err_dup;
    logic             r_err_par;

    // Output register; error flags are qualified by valid as they are loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_s          <= '0;
            r_c_out      <= 1'b0;
            r_err_in_par <= 1'b0;
            r_err_dup    <= 1'b0;
            r_err_par    <= 1'b0;
        end else if (w_advance) begin
            r_out_valid  <= w_vld_fin;
            r_s          <= w_s1_fin;
            r_c_out      <= w_c1_fin;
            r_err_in_par <= w_vld_fin & w_ein_fin;
            r_err_dup    <= w_vld_fin & w_dup_fin;
            r_err_par    <= w_vld_fin & w_par_fin;
        end
    end

    logic             r_err_sticky;
    logic [CNT_W-1:0] r_err_count;
    logic             w_out_xfer;
    logic             w_any_err;

    assign w_out_xfer = r_out_valid & out_ready;
    assign w_any_err  = r_err_in_par | r_err_dup | r_err_par;

    // Error record: an erroring output transfer beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (w_out_xfer & w_any_err) begin
            r_err_sticky <= 1'b1;
            if (clr_err) begin
                r_err_count <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (r_err_count != {CNT_W{1'b1}}) begin
                r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (clr_err) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end
    end

    assign out_valid  = r_out_valid;
    assign s          = r_s;
    assign c_out      = r_c_out;
    assign err_in_par = r_err_in_par;
    assign err_dup    = r_err_dup;
    assign err_par    = r_err_par;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule

// File: doc/dup_pipelined_csel_adder.md
Name: dup_pipelined_csel_adder

Overview:
- Parametrised, pipelined successor to the 64-bit duplicated carry-select adder with parity prediction.
- Adds WIDTH-bit operands in STAGES carry-pipelined segments, each built from two independent carry-select chains.
- Checks the two chains against each other and checks predicted sum parity against actual.
- Flags input-parity, duplication and parity errors, and keeps a sticky error record and counter; sits in the checked datapath ahead of the ALU result bus.

Parameters:
- WIDTH, 64, operand/sum width; must be a multiple of STAGES.
- STAGES, 4, pipeline segments; latency in cycles; WIDTH/STAGES must be a multiple of BLOCK.
- BLOCK, 4, carry-select block size inside a segment.
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block accepts operand this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- pa  in  1  even parity of a (pa = XOR of all bits of a)
- pb  in  1  even parity of b
- c_in  in  1  carry in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum from chain 1
- c_out  out  1  carry out from chain 1
- err_in_par  out  1  input parity mismatch for this result
- err_dup  out  1  chain 1 and chain 2 sum/carry differ for this result
- err_par  out  1  predicted parity differs from actual sum parity
- err_sticky  out  1  any error since reset/clear
- err_count  out  CNT_W  number of erroneous results delivered
- clr_err  in  1  synchronous clear of err_sticky/err_count

Behaviour:
- Reset values (async, rst_n low): all pipeline valid bits 0, out_valid 0, s 0, c_out 0, all err_* 0, err_count 0. in_ready is 1 in reset.
- Handshake:
  - advance = !out_valid | out_ready.
  - in_ready = advance.
  - On advance every stage shifts one step and a bubble moves like data.
  - A transfer occurs when in_valid & in_ready (input) or out_valid & out_ready (output).
  - Holding in_valid high with out_ready high gives 1 result/cycle; throughput is never lost.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall.
- Stage k (0..STAGES-1):
  - Adds bits [k*SEG +: SEG], with SEG = WIDTH/STAGES.
  - Chain 1 and chain 2 each take their own registered carry from stage k-1; stage 0 takes c_in for both.
  - Each chain is carry-select by BLOCK: both carry assumptions are precomputed and selected by the incoming carry.
  - Operand bits not yet consumed are carried forward in registers.
  - Sum bits already produced are carried forward in registers, once per chain.
- Parity prediction:
  - Predicted = pa ^ pb ^ XOR of the carry-into vector (c_in and the carry into every bit 1..WIDTH-1), computed from chain 2 carries.
  - Actual = XOR of chain-1 sum.
  - err_par = predicted != actual.
- err_in_par = (pa != ^a) | (pb != ^b). Evaluated at input transfer and travels with the data.
- err_dup = (chain1 sum != chain2 sum) | (chain1 c_out != chain2 c_out).
- All err_* outputs are qualified by out_valid; they are 0 when out_valid is 0.
- Error accounting:
  - On an output transfer with any err_* set: err_sticky <= 1 and err_count increments.
  - err_count saturates at all-ones and does not wrap.
- clr_err: clears err_sticky and err_count next cycle. If it coincides with an erroring output transfer, the error wins: err_sticky=1, err_count=1.
- Stall: outputs and all stage registers hold while out_valid & !out_ready; out_valid never drops without a transfer.
- Reset mid-operation: in-flight operands are discarded, no output is produced for them, and counters clear.

Optional Feature:
- FAULT_INJECT_EN defined:
  - Adds input port inj_mask (WIDTH bits).
  - inj_mask is XORed onto chain-2 sum in the last stage, before comparison; s is unaffected.
  - A nonzero mask on a result sets err_dup.
  - A mask with odd popcount also sets err_par only if the parity check uses the chain-2 sum. It does not, so err_par stays clean; this exercises the duplication checker in isolation.
- FAULT_INJECT_EN not defined: no port, no XOR logic, chain 2 compared unmodified.

Test Plan (WIDTH=64, STAGES=4):
- a=FFFF_FFFF_FFFF_FFFF, b=1, pa=0, pb=1, c_in=0, out_ready=1 -> 4 cycles later out_valid=1, s=0, c_out=1, all err_*=0, err_count=0.
- 8 back-to-back operands a=i, b=i*3 (i=0..7, correct parity); out_ready low cycles 5-7 -> in_ready low same cycles, all 8 sums 4*i delivered in order, none lost or duplicated.
- a=5, b=3, pa=1 (wrong; correct 0), pb=0 -> s=8, err_in_par=1, err_sticky=1, err_count=1.
- FAULT_INJECT_EN, inj_mask=0x20, a=1, b=1 -> s=2, err_dup=1, err_par=0, err_count increments.
- clr_err asserted in the same cycle as an erroring output transfer (err_count previously 5) -> err_count=1, err_sticky=1.
- rst_n pulsed low with 3 operands in flight -> no out_valid for them, err_count=0; the next operand produces its result 4 cycles after acceptance.
